// File: rtl/serdesphy_pkg.sv
// Shared SerDes PHY constants: PLL-cal FSM encoding, default trim, and the timing
// budgets the calibration sequencer is sized against.
package serdesphy_pkg;

    localparam logic [2:0] CAL_IDLE       = 3'd0;
    localparam logic [2:0] CAL_TRY_RST    = 3'd1;
    localparam logic [2:0] CAL_TRY_WAIT   = 3'd2;
    localparam logic [2:0] CAL_EVAL       = 3'd3;
    localparam logic [2:0] CAL_APPLY_RST  = 3'd4;
    localparam logic [2:0] CAL_APPLY_WAIT = 3'd5;

    localparam logic [3:0] PLL_DEFAULT_TRIM = 4'h8;

    // The controller qualifies lock over PLL_LOCK_QUAL_CYCLES; the cal timeout
    // must cover that plus the controller's pipeline margin.
    localparam int PLL_LOCK_QUAL_CYCLES = 2400;
    localparam int CAL_RST_CYCLES       = 24;
    localparam int CAL_LOCK_TIMEOUT     = 3000;

    function automatic logic [3:0] cal_midpoint(input logic [3:0] lo, input logic [3:0] hi);
        logic [4:0] sum;
        sum = {1'b0, lo} + {1'b0, hi};
        return sum[4:1];
    endfunction

endpackage

// File: rtl/serdesphy_cal_timer.sv
// Loadable 16-bit saturating cycle counter; tc flags cnt == tc_val.
// clr restarts the count from zero on the next edge.
module serdesphy_cal_timer (
    input  logic        clk_ref_24m,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [15:0] tc_val,
    output logic        tc
);

    logic [15:0] cnt;

    always_ff @(posedge clk_ref_24m or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'd0;
        end else if (clr) begin
            cnt <= 16'd0;
        end else if (cnt != 16'hffff) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign tc = (cnt == tc_val);

endmodule

// File: rtl/serdesphy_pll_cal.sv
// VCO coarse-trim calibration: sweeps all 16 trim codes with a PLL reset/lock trial
// each, then applies and confirms the midpoint of the locking window. All outputs registered.
module serdesphy_pll_cal
    import serdesphy_pkg::*;
#(
    parameter int         RST_CYCLES   = CAL_RST_CYCLES,
    parameter int         LOCK_TIMEOUT = CAL_LOCK_TIMEOUT,
    parameter logic [3:0] DEFAULT_TRIM = PLL_DEFAULT_TRIM
) (
    input  logic        clk_ref_24m,
    input  logic        rst_n,
    input  logic        cal_start,
    input  logic        cal_abort,
    input  logic        pll_lock,
    input  logic        pll_error,
    output logic [3:0]  vco_trim,
    output logic        pll_rst,
    output logic        cal_busy,
    output logic        cal_done,
    output logic        cal_fail,
    output logic [3:0]  cal_result,
    output logic [15:0] lock_map
);

    localparam logic [15:0] RST_TC  = 16'(RST_CYCLES - 1);
    localparam logic [15:0] LOCK_TC = 16'(LOCK_TIMEOUT - 1);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [3:0]  code;
    logic [3:0]  lo;
    logic [3:0]  hi;
    logic        found;
    logic        tmr_clr;
    logic        tmr_tc;
    logic [15:0] tmr_tc_val;
    logic        in_wait;
    logic        wait_miss;
    logic        abort_hit;

    assign in_wait   = (state == CAL_TRY_WAIT) || (state == CAL_APPLY_WAIT);
    assign wait_miss = pll_error || tmr_tc;
    assign abort_hit = cal_abort && (state != CAL_IDLE);
    assign tmr_tc_val = in_wait ? LOCK_TC : RST_TC;
    // Every trial phase starts on a state change, so that alone restarts the timer.
    assign tmr_clr   = (state_nxt != state) || (state == CAL_IDLE);

    serdesphy_cal_timer u_timer (
        .clk_ref_24m (clk_ref_24m),
        .rst_n       (rst_n),
        .clr         (tmr_clr),
        .tc_val      (tmr_tc_val),
        .tc          (tmr_tc)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            CAL_IDLE:       if (cal_start) state_nxt = CAL_TRY_RST;
            CAL_TRY_RST:    if (tmr_tc) state_nxt = CAL_TRY_WAIT;
            CAL_TRY_WAIT: begin
                if (pll_lock || wait_miss) begin
                    state_nxt = (code == 4'hf) ? CAL_EVAL : CAL_TRY_RST;
                end
            end
            CAL_EVAL:       state_nxt = found ? CAL_APPLY_RST : CAL_IDLE;
            CAL_APPLY_RST:  if (tmr_tc) state_nxt = CAL_APPLY_WAIT;
            CAL_APPLY_WAIT: if (pll_lock || wait_miss) state_nxt = CAL_IDLE;
            default:        state_nxt = CAL_IDLE;
        endcase
        if (abort_hit) begin
            state_nxt = CAL_IDLE;
        end
    end

    always_ff @(posedge clk_ref_24m or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CAL_IDLE;
            code       <= 4'd0;
            lo         <= 4'hf;
            hi         <= 4'd0;
            found      <= 1'b0;
            vco_trim   <= DEFAULT_TRIM;
            pll_rst    <= 1'b0;
            cal_busy   <= 1'b0;
            cal_done   <= 1'b0;
            cal_fail   <= 1'b0;
            cal_result <= DEFAULT_TRIM;
            lock_map   <= 16'd0;
        end else begin
            state    <= state_nxt;
            cal_busy <= (state_nxt != CAL_IDLE);
            if (abort_hit) begin
                pll_rst  <= 1'b0;
                cal_fail <= 1'b1;
                vco_trim <= cal_result;
            end else begin
                case (state)
                    CAL_IDLE: begin
                        if (cal_start) begin
                            cal_done <= 1'b0;
                            cal_fail <= 1'b0;
                            lock_map <= 16'd0;
                            code     <= 4'd0;
                            lo       <= 4'hf;
                            hi       <= 4'd0;
                            found    <= 1'b0;
                            vco_trim <= 4'd0;
                            pll_rst  <= 1'b1;
                        end
                    end
                    CAL_TRY_RST, CAL_APPLY_RST: begin
                        if (tmr_tc) pll_rst <= 1'b0;
                    end
                    CAL_TRY_WAIT: begin
                        if (pll_lock || wait_miss) begin
                            // Lock wins over a coincident error or timeout.
                            if (pll_lock) begin
                                lock_map[code] <= 1'b1;
                                if (code < lo) lo <= code;
                                hi    <= code;
                                found <= 1'b1;
                            end
                            if (code != 4'hf) begin
                                code     <= code + 4'd1;
                                vco_trim <= code + 4'd1;
                                pll_rst  <= 1'b1;
                            end
                        end
                    end
                    CAL_EVAL: begin
                        if (found) begin
                            vco_trim <= cal_midpoint(lo, hi);
                            pll_rst  <= 1'b1;
                        end else begin
                            cal_fail <= 1'b1;
                            vco_trim <= cal_result;
                        end
                    end
                    CAL_APPLY_WAIT: begin
                        // vco_trim still holds the candidate under trial.
                        if (pll_lock) begin
                            cal_result <= vco_trim;
                            cal_done   <= 1'b1;
                        end else if (wait_miss) begin
                            cal_fail <= 1'b1;
                            vco_trim <= cal_result;
                        end
                    end
                    default: begin
                        pll_rst <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serdesphy_pll_cal.sv
// Directed bench for serdesphy_pll_cal with a trim-mask PLL lock model and
// shortened trial timing.
module tb_serdesphy_pll_cal;

    logic        clk_ref_24m = 1'b0;
    logic        rst_n       = 1'b0;
    logic        cal_start   = 1'b0;
    logic        cal_abort   = 1'b0;
    logic        pll_error   = 1'b0;
    logic        pll_lock;
    logic [3:0]  vco_trim;
    logic        pll_rst;
    logic        cal_busy;
    logic        cal_done;
    logic        cal_fail;
    logic [3:0]  cal_result;
    logic [15:0] lock_map;

    logic [15:0] lock_mask = 16'd0;
    logic [7:0]  rel_cnt   = 8'd0;
    int          passed    = 0;
    int          failed    = 0;
    int          total     = 0;
    int          rst_hi    = 0;

    serdesphy_pll_cal #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (40),
        .DEFAULT_TRIM (4'h8)
    ) dut (
        .clk_ref_24m (clk_ref_24m),
        .rst_n       (rst_n),
        .cal_start   (cal_start),
        .cal_abort   (cal_abort),
        .pll_lock    (pll_lock),
        .pll_error   (pll_error),
        .vco_trim    (vco_trim),
        .pll_rst     (pll_rst),
        .cal_busy    (cal_busy),
        .cal_done    (cal_done),
        .cal_fail    (cal_fail),
        .cal_result  (cal_result),
        .lock_map    (lock_map)
    );

    always #5 clk_ref_24m = ~clk_ref_24m;

    // PLL model: locks a few cycles after reset release when the trim is in lock_mask.
    always @(posedge clk_ref_24m) begin
        if (pll_rst) rel_cnt <= 8'd0;
        else if (rel_cnt != 8'hff) rel_cnt <= rel_cnt + 8'd1;
    end
    assign pll_lock = lock_mask[vco_trim] && !pll_rst && (rel_cnt >= 8'd6);

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_pulse();
        @(negedge clk_ref_24m);
        cal_start = 1'b1;
        @(negedge clk_ref_24m);
        cal_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (cal_busy && n < 3000) begin
            @(negedge clk_ref_24m);
            n++;
        end
        chk(tag, {15'd0, cal_busy}, 16'd0);
    endtask

    task automatic wait_trim(input string tag, input logic [3:0] val, input logic want_rst);
        int n = 0;
        while (!(vco_trim == val && pll_rst == want_rst && cal_busy) && n < 3000) begin
            @(negedge clk_ref_24m);
            n++;
        end
        chk(tag, {15'd0, (n < 3000)}, 16'd1);
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] trim, input logic rst,
                            input logic done, input logic fail, input logic [3:0] res,
                            input logic [15:0] map);
        chk({tag, "_trim"}, {12'd0, vco_trim}, {12'd0, trim});
        chk({tag, "_pll_rst"}, {15'd0, pll_rst}, {15'd0, rst});
        chk({tag, "_done"}, {15'd0, cal_done}, {15'd0, done});
        chk({tag, "_fail"}, {15'd0, cal_fail}, {15'd0, fail});
        chk({tag, "_result"}, {12'd0, cal_result}, {12'd0, res});
        chk({tag, "_map"}, lock_map, map);
    endtask

    initial begin
        #23;
        chk("reset_busy", {15'd0, cal_busy}, 16'd0);
        chk_outs("reset", 4'h8, 1'b0, 1'b0, 1'b0, 4'h8, 16'h0000);
        @(negedge clk_ref_24m);
        rst_n = 1'b1;

        // No code locks: sixteen timeouts then fail with default trim.
        lock_mask = 16'h0000;
        start_pulse();
        chk("start_busy", {15'd0, cal_busy}, 16'd1);
        chk("start_pll_rst", {15'd0, pll_rst}, 16'd1);
        chk("start_trim", {12'd0, vco_trim}, 16'd0);
        while (pll_rst && rst_hi < 100) begin
            rst_hi++;
            @(negedge clk_ref_24m);
        end
        chk("rst_width", 16'(rst_hi), 16'd4);
        wait_idle("nolock_idle");
        chk_outs("nolock", 4'h8, 1'b0, 1'b0, 1'b1, 4'h8, 16'h0000);

        // Codes 5..10 lock: midpoint 7.
        lock_mask = 16'h07E0;
        start_pulse();
        chk("win_clears_fail", {15'd0, cal_fail}, 16'd0);
        wait_idle("win_idle");
        chk_outs("win", 4'h7, 1'b0, 1'b1, 1'b0, 4'h7, 16'h07E0);

        // Only code 15 locks: midpoint must not wrap.
        lock_mask = 16'h8000;
        start_pulse();
        wait_idle("top_idle");
        chk_outs("top", 4'hf, 1'b0, 1'b1, 1'b0, 4'hf, 16'h8000);

        // Codes 0 and 15 lock with a gap: midpoint 7, which the model also locks at apply.
        lock_mask = 16'h8001;
        start_pulse();
        wait_trim("gap_reach15", 4'hf, 1'b1);
        lock_mask = 16'h8081;
        wait_idle("gap_idle");
        chk_outs("gap", 4'h7, 1'b0, 1'b1, 1'b0, 4'h7, 16'h8001);

        // Error during code 3's wait skips it within one cycle.
        lock_mask = 16'h0018;
        start_pulse();
        wait_trim("err_reach3", 4'h3, 1'b0);
        pll_error = 1'b1;
        @(negedge clk_ref_24m);
        pll_error = 1'b0;
        chk("err_next_trim", {12'd0, vco_trim}, 16'd4);
        chk("err_next_rst", {15'd0, pll_rst}, 16'd1);
        wait_idle("err_idle");
        chk_outs("err", 4'h4, 1'b0, 1'b1, 1'b0, 4'h4, 16'h0010);

        // Establish result 9, then abort during code 6.
        lock_mask = 16'h0700;
        start_pulse();
        wait_idle("pre9_idle");
        chk("pre9_result", {12'd0, cal_result}, 16'd9);
        lock_mask = 16'h07E0;
        start_pulse();
        wait_trim("abort_reach6", 4'h6, 1'b1);
        cal_start = 1'b1;
        @(negedge clk_ref_24m);
        cal_start = 1'b0;
        chk("busy_start_ignored_busy", {15'd0, cal_busy}, 16'd1);
        chk("busy_start_ignored_trim", {12'd0, vco_trim}, 16'd6);
        chk("busy_start_ignored_map", lock_map, 16'h0020);
        cal_abort = 1'b1;
        @(negedge clk_ref_24m);
        cal_abort = 1'b0;
        chk("abort_busy", {15'd0, cal_busy}, 16'd0);
        chk_outs("abort", 4'h9, 1'b0, 1'b0, 1'b1, 4'h9, 16'h0020);

        // Codes 4..8 lock in the sweep, apply trial at 6 times out.
        lock_mask = 16'h01F0;
        start_pulse();
        wait_trim("apply_reach15", 4'hf, 1'b1);
        lock_mask = 16'h0000;
        wait_idle("apply_idle");
        chk_outs("apply_to", 4'h9, 1'b0, 1'b0, 1'b1, 4'h9, 16'h01F0);

        // Async reset mid-sweep.
        lock_mask = 16'h07E0;
        start_pulse();
        wait_trim("arst_reach7", 4'h7, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {15'd0, cal_busy}, 16'd0);
        chk_outs("arst", 4'h8, 1'b0, 1'b0, 1'b0, 4'h8, 16'h0000);
        @(negedge clk_ref_24m);
        rst_n = 1'b1;
        @(negedge clk_ref_24m);
        chk("arst_stays_idle", {15'd0, cal_busy}, 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serdesphy_pll_cal.md
# serdesphy_pll_cal

Automatic VCO coarse-trim calibration sequencer for the SerDes PHY PLL. The block sweeps all 16 `vco_trim` codes and, for each code, pulses `pll_rst` and waits for the validated `pll_lock`. It then programs the midpoint of the locking window and confirms lock. It sits between the CSR block and the PLL controller, and drives the controller's `vco_trim` and `pll_rst` inputs in the `clk_ref_24m` domain.

## Interface
- `RST_CYCLES`, default 24: cycles `pll_rst` is held high per trial (1 µs).
- `LOCK_TIMEOUT`, default 3000: cycles allowed for `pll_lock` after `pll_rst` release. Must exceed the controller's 2400-cycle lock qualification plus pipeline margin.
- `DEFAULT_TRIM`, default 4'h8: trim code driven when no calibration result exists.
- `clk_ref_24m  input  1`: 24 MHz reference clock.
- `rst_n  input  1`: reset, asynchronous, active-low.
- `cal_start  input  1`: one-cycle start request.
- `cal_abort  input  1`: abort request.
- `pll_lock  input  1`: validated lock from the PLL controller.
- `pll_error  input  1`: PLL error flag from the PLL controller.
- `vco_trim  output  4`: trim code to the PLL controller.
- `pll_rst  output  1`: PLL reset to the PLL controller.
- `cal_busy  output  1`: calibration in progress.
- `cal_done  output  1`: sticky; last calibration succeeded.
- `cal_fail  output  1`: sticky; last calibration failed or was aborted.
- `cal_result  output  4`: last successful trim code.
- `lock_map  output  16`: bit n set if trim code n locked during the last sweep.

## Operation
- States: IDLE, TRY_RST, TRY_WAIT, EVAL, APPLY_RST, APPLY_WAIT.
- IDLE: `vco_trim` = `cal_result`. When `cal_start` = 1:
  - clear `cal_done`, `cal_fail` and `lock_map`;
  - set code = 0, lo = 15, hi = 0, found = 0;
  - go to TRY_RST.
- TRY_RST: `vco_trim` = code, `pll_rst` = 1. Hold for `RST_CYCLES`, then go to TRY_WAIT with the timer cleared.
- TRY_WAIT: `pll_rst` = 0, timer increments each cycle.
  - `pll_lock` = 1: set `lock_map[code]`; lo = min(lo, code); hi = code; found = 1.
  - `pll_error` = 1 or timer = `LOCK_TIMEOUT`-1: the code counts as not locked.
  - In every case the next state is TRY_RST with code+1; after code 15, go to EVAL.
- EVAL:
  - found = 0: set `cal_fail`, go to IDLE.
  - Otherwise: candidate = (lo + hi) >> 1, using a 5-bit sum truncated to 4 bits. Go to APPLY_RST.
  - The window is not checked for contiguity; the midpoint of the first and last locking codes is used regardless of gaps.
- APPLY_RST / APPLY_WAIT: same as TRY_RST / TRY_WAIT, but with `vco_trim` = candidate.
  - Lock: `cal_result` = candidate, set `cal_done`, go to IDLE.
  - Timeout or error: set `cal_fail`, go to IDLE; `cal_result` is unchanged.
- `cal_start` while `cal_busy` is ignored.
- `cal_abort` in any non-IDLE state:
  - takes priority over every other event in the same cycle;
  - next state is IDLE, `pll_rst` = 0, `cal_fail` set, `cal_result` unchanged;
  - `lock_map` keeps its partial contents.
- `cal_busy` = 1 exactly when state ≠ IDLE.

## Timing
- Reset values: `vco_trim` = `DEFAULT_TRIM`, `pll_rst` = 0, `cal_busy` = 0, `cal_done` = 0, `cal_fail` = 0, `cal_result` = `DEFAULT_TRIM`, `lock_map` = 0. State is IDLE.
- All outputs are registered.
- `cal_start` at cycle t gives `cal_busy` = 1 and `pll_rst` = 1 at t+1.
- `pll_rst` is high for exactly `RST_CYCLES` cycles per trial.
- `pll_lock` is sampled every cycle in the WAIT states. A lock seen on the cycle `pll_rst` falls is accepted.
- Worst-case sweep: 16 × (`RST_CYCLES` + `LOCK_TIMEOUT`) + 1 cycles, then apply.
- The timer is 16 bits and saturates; it never wraps.
- Asynchronous reset mid-sweep returns all outputs to reset values immediately.

## Structure
- Shared package `serdesphy_pkg` holds the state encoding, `DEFAULT_TRIM`, and the default timing constants alongside the PLL lock-count constants.
- One sub-module, `serdesphy_cal_timer`: loadable 16-bit saturating counter with a terminal-count flag, reused by both the RST and WAIT states.

## Test plan
- Lock model locks for codes 5–10 → `lock_map` = 16'h07E0, candidate 7, `cal_done` = 1, `cal_result` = 7, `vco_trim` = 7.
- No code locks → after 16 timeouts, `cal_fail` = 1, `cal_result` = 8, `vco_trim` = 8, `pll_rst` = 0.
- Only code 15 locks → `lock_map` = 16'h8000, `cal_result` = 15. Codes 0 and 15 lock (gap) → `cal_result` = 7.
- `pll_error` asserted during code 3's wait → code 3 is skipped within 1 cycle, `lock_map[3]` = 0, and the sweep continues at code 4.
- `cal_abort` during code 6 with a previous `cal_result` of 9 → IDLE next cycle, `cal_fail` = 1, `vco_trim` = 9, `pll_rst` = 0. A `cal_start` pulse while busy has no effect.
- Codes 4–8 lock in the sweep but the apply trial times out → `cal_fail` = 1, `cal_result` unchanged. `rst_n` pulsed mid-sweep → all outputs return to reset values.
